// File: rtl/cordic_pkg.sv
// Shared CORDIC vectoring definitions: FSM encoding, Q5.11 angle constants and the atan table.
// The gain-compensation constant is used only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  localparam int FRAC_BITS = 11;
  localparam int ANGLE_W   = 16;
  localparam int ROM_IDX_W = 8;

  localparam logic signed [ANGLE_W-1:0] PI_Q      = 16'sd6434;
  localparam logic signed [ANGLE_W-1:0] HALF_PI_Q = 16'sd3217;
  localparam logic signed [ANGLE_W-1:0] INV_K_Q   = 16'sd1244;

  // atan(2^-i) rounded to the nearest Q5.11 LSB; it rounds to zero from i=12 onward.
  function automatic logic signed [ANGLE_W-1:0] atan_q(input logic [ROM_IDX_W-1:0] idx);
    logic signed [ANGLE_W-1:0] val;
    case (idx)
      8'd0:    val = 16'sd1608;
      8'd1:    val = 16'sd950;
      8'd2:    val = 16'sd502;
      8'd3:    val = 16'sd255;
      8'd4:    val = 16'sd128;
      8'd5:    val = 16'sd64;
      8'd6:    val = 16'sd32;
      8'd7:    val = 16'sd16;
      8'd8:    val = 16'sd8;
      8'd9:    val = 16'sd4;
      8'd10:   val = 16'sd2;
      8'd11:   val = 16'sd1;
      default: val = 16'sd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup: iteration index -> atan(2^-i) in Q5.11.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [ROM_IDX_W-1:0]      idx_i,
  output logic signed [ANGLE_W-1:0] atan_o
);

  assign atan_o = atan_q(idx_i);

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: (x,y) -> atan2(y,x) and magnitude, one micro-rotation per cycle.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K before it is saturated.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int n_iterations = 20
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  output logic signed [DATA_WIDTH-1:0] angle_out,
  output logic signed [DATA_WIDTH-1:0] magnitude,
  output logic                         valid_out,
  output logic                         busy,
  output cordic_state_e                state_o
);

  localparam int IW = DATA_WIDTH + 2;
  localparam int PW = IW + ANGLE_W;
  localparam logic [ROM_IDX_W-1:0] LAST_ITER = ROM_IDX_W'(n_iterations - 1);
  localparam logic signed [PW-1:0] MAG_MAX   = PW'((2 ** (DATA_WIDTH - 1)) - 1);

  cordic_state_e                state_q, state_d;
  logic signed [IW-1:0]         x_q, x_d, y_q, y_d;
  logic signed [DATA_WIDTH-1:0] z_q, z_d;
  logic [ROM_IDX_W-1:0]         iter_q, iter_d;
  logic                         zero_q, zero_d;
  logic signed [DATA_WIDTH-1:0] angle_q, angle_d, mag_q, mag_d;
  logic                         valid_q, valid_d, busy_q, busy_d;

  logic signed [ANGLE_W-1:0]    atan_w;
  logic signed [DATA_WIDTH-1:0] atan_ext;
  logic signed [IW-1:0]         x_sh, y_sh;
  logic signed [PW-1:0]         mag_full;
  logic signed [DATA_WIDTH-1:0] mag_sat;

  cordic_atan_rom u_rom (
    .idx_i  (iter_q),
    .atan_o (atan_w)
  );

  assign atan_ext = DATA_WIDTH'(atan_w);
  assign x_sh     = x_q >>> iter_q;
  assign y_sh     = y_q >>> iter_q;

`ifdef CORDIC_GAIN_COMP_EN
  assign mag_full = (PW'(x_q) * PW'(INV_K_Q)) >>> FRAC_BITS;
`else
  assign mag_full = PW'(x_q);
`endif

  // x is non-negative once PRE has folded the vector into the right half-plane.
  assign mag_sat = (mag_full > MAG_MAX) ? MAG_MAX[DATA_WIDTH-1:0] :
                   (mag_full < 0)       ? '0 : mag_full[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          x_d     = IW'(x_in);
          y_d     = IW'(y_in);
          z_d     = '0;
          iter_d  = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          busy_d  = 1'b1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        // Left half-plane vectors are turned by a quarter turn so the iterations converge.
        if (x_q < 0) begin
          if (y_q >= 0) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = DATA_WIDTH'(HALF_PI_Q);
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -DATA_WIDTH'(HALF_PI_Q);
          end
        end else begin
          z_d = '0;
        end
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (y_q[IW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_ext;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_ext;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A zero vector has no direction; report angle 0 rather than the accumulated sum.
        angle_d = zero_q ? '0 : z_q;
        mag_d   = mag_sat;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign angle_out = angle_q;
  assign magnitude = mag_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring; magnitudes track whether CORDIC_GAIN_COMP_EN is defined.
module tb_cordic_vectoring;
  import cordic_pkg::*;

  localparam int DW  = 16;
  localparam int NI  = 20;
  localparam int LAT = NI + 2;
  localparam int TOL = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int MAG_UNIT = 2048;
  localparam int MAG_DIAG = 2896;
`else
  localparam int MAG_UNIT = 3373;
  localparam int MAG_DIAG = 4770;
`endif
  localparam int MAG_SAT = 32767;

  logic                 clk = 1'b0;
  logic                 arst = 1'b1;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] y_in = '0;
  logic signed [DW-1:0] angle_out;
  logic signed [DW-1:0] magnitude;
  logic                 valid_out;
  logic                 busy;
  cordic_state_e        state_dbg;

  int n_vec = 0;
  int n_err = 0;

  cordic_vectoring #(.DATA_WIDTH(DW), .n_iterations(NI)) dut (
    .clk       (clk),
    .arst      (arst),
    .valid_in  (valid_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .magnitude (magnitude),
    .valid_out (valid_out),
    .busy      (busy),
    .state_o   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    n_vec++;
    assert (diff <= TOL && diff >= -TOL) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the capture edge.
  task automatic start_req(input int x, input int y);
    x_in     = DW'(x);
    y_in     = DW'(y);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (valid_out !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  task automatic chk_result(input string tag, input int exp_ang, input int exp_mag);
    chk_tol({tag, "_angle"}, int'(angle_out), exp_ang);
    chk_tol({tag, "_mag"}, int'(magnitude), exp_mag);
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) pulses++;
    end
    chk({tag, "_extra_valid"}, pulses, 0);
  endtask

  initial begin
    int hold_ang;
    #1;
    chk("rst_angle", int'(angle_out), 0);
    chk("rst_mag", int'(magnitude), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(state_dbg), int'(ST_IDLE));
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    start_req(2048, 0);
    chk("unit_x_busy_rise", int'(busy), 1);
    wait_done("unit_x", LAT);
    chk_result("unit_x", 0, MAG_UNIT);
    @(negedge clk);
    chk("unit_x_pulse_width", int'(valid_out), 0);
    hold_ang = int'(angle_out);
    repeat (3) @(negedge clk);
    chk_tol("unit_x_hold_mag", int'(magnitude), MAG_UNIT);
    chk("unit_x_hold_angle", int'(angle_out), hold_ang);

    start_req(0, 2048);
    wait_done("unit_y", LAT);
    chk_result("unit_y", 3217, MAG_UNIT);

    // Back-to-back: next request issued in the IDLE cycle that follows DONE.
    start_req(-2048, 0);
    chk("b2b_accept_busy", int'(busy), 1);
    chk("b2b_valid_low", int'(valid_out), 0);
    wait_done("neg_x", LAT);
    chk_result("neg_x", 6434, MAG_UNIT);
    @(negedge clk);

    start_req(0, 0);
    wait_done("zero", LAT);
    chk("zero_angle", int'(angle_out), 0);
    chk("zero_mag", int'(magnitude), 0);
    @(negedge clk);

    start_req(2048, 2048);
    wait_done("diag_q1", LAT);
    chk_result("diag_q1", 1608, MAG_DIAG);
    @(negedge clk);

    start_req(-2048, -2048);
    wait_done("diag_q3", LAT);
    chk_result("diag_q3", -4825, MAG_DIAG);
    @(negedge clk);

    start_req(32767, 32767);
    wait_done("sat", LAT);
    chk("sat_mag", int'(magnitude), MAG_SAT);
    chk_tol("sat_angle", int'(angle_out), 1608);
    @(negedge clk);

    // A second request while busy must be dropped.
    start_req(2048, 2048);
    repeat (5) @(negedge clk);
    start_req(0, 2048);
    wait_done("ignore", LAT - 6);
    chk_result("ignore", 1608, MAG_DIAG);
    count_pulses("ignore", 30);

    // Abort at iteration 5, then a fresh request must still complete.
    start_req(0, 2048);
    repeat (6) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("abort_angle", int'(angle_out), 0);
    chk("abort_mag", int'(magnitude), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid_out), 0);
    chk("abort_state", int'(state_dbg), int'(ST_IDLE));
    @(negedge clk);
    arst = 1'b0;
    count_pulses("abort", 30);
    start_req(2048, 0);
    wait_done("post_abort", LAT);
    chk_result("post_abort", 0, MAG_UNIT);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
